// File: rtl/lcd_src_sched_pkg.sv
// Shared encodings for the LCD pixel-source scheduler: source codes, FSM state
// codes and the RGB565 colour-bar table.
package lcd_sched_pkg;

  localparam logic [1:0] SRC_FIXED    = 2'd0;
  localparam logic [1:0] SRC_BAR      = 2'd1;
  localparam logic [1:0] SRC_FIFO     = 2'd2;
  localparam logic [1:0] SRC_RESERVED = 2'd3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_UNDERRUN = 2'd2;

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] norm_src(input logic [1:0] sel);
    logic [1:0] s;
    case (sel)
      SRC_BAR:  s = SRC_BAR;
      SRC_FIFO: s = SRC_FIFO;
      default:  s = SRC_FIXED;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lcd_src_sched_if.sv
// Pixel request/response and FWFT FIFO signals between the LCD driver side
// (master) and the source scheduler (slave).
interface lcd_src_sched_if;
  logic        data_req;
  logic [15:0] pixel_data;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;

  modport master (
    output data_req,
    input  pixel_data,
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en
  );

  modport slave (
    input  data_req,
    output pixel_data,
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en
  );
endinterface

// File: rtl/lcd_src_sched_colorbar.sv
// Eight vertical colour bars: bar index advances every bar_w served pixels,
// saturates on the last bar and restarts at each line.
module lcd_colorbar_gen
  import lcd_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        clr,
  input  logic [10:0] x_cnt,
  input  logic [7:0]  bar_w,
  output logic [15:0] color
);

  logic [2:0] idx_q, idx_d, idx_s;
  logic [7:0] cnt_q, cnt_d, cnt_s;

  // x_cnt==0 restarts the bar walk even if the line-end clear was missed.
  always_comb begin
    idx_s = (x_cnt == 11'd0) ? 3'd0 : idx_q;
    cnt_s = (x_cnt == 11'd0) ? 8'd0 : cnt_q;
    color = bar_color(idx_s);
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (clr) begin
      idx_d = 3'd0;
      cnt_d = 8'd0;
    end else if (step) begin
      if (({1'b0, cnt_s} + 9'd1) >= {1'b0, bar_w}) begin
        cnt_d = 8'd0;
        idx_d = (idx_s == 3'd7) ? 3'd7 : idx_s + 3'd1;
      end else begin
        cnt_d = cnt_s + 8'd1;
        idx_d = idx_s;
      end
    end else begin
      idx_d = idx_q;
      cnt_d = cnt_q;
    end
  end

  // Bar position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 3'd0;
      cnt_q <= 8'd0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_src_sched.sv
// Pixel-source scheduler (fixed colour / colour bar / FWFT FIFO) switching only
// at frame boundaries. Define LCD_SRC_STATS_EN to add underrun_cnt/frame_cnt.
module lcd_src_sched
  import lcd_sched_pkg::*;
#(
  parameter logic [15:0] UNDERRUN_COLOR = 16'hF800,
  parameter logic [15:0] IDLE_COLOR     = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  lcd_src_sched_if.slave pix,
  input  logic [10:0]  h_disp,
  input  logic [10:0]  v_disp,
  input  logic [1:0]   src_sel,
  input  logic [15:0]  fixed_color,
  output logic [1:0]   active_src,
  output logic         frame_done,
  output logic         underrun,
  input  logic         err_clr
`ifdef LCD_SRC_STATS_EN
  ,
  output logic [15:0]  underrun_cnt,
  output logic [15:0]  frame_cnt
`endif
);

  logic [1:0]  state_q, state_d;
  logic        req_dly_q;
  logic [10:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [10:0] h_disp_q, v_disp_q;
  logic [15:0] fixed_q, pixel_q, pixel_d;
  logic [1:0]  active_src_q;
  logic        frame_done_q, underrun_q, underrun_d;

  logic        start_s, line_end_s, frame_end_s, serving_s, run_like_s;
  logic        rd_en_s, urun_set_s, lost_s;
  logic [1:0]  src_eff_s;
  logic [10:0] h_eff_s;
  logic [15:0] fixed_eff_s, bar_color_s;
  logic [7:0]  bar_w_s;

  // On the frame-start pixel the freshly sampled inputs are used directly.
  always_comb begin
    start_s     = (state_q == ST_IDLE) & pix.data_req & ~req_dly_q;
    line_end_s  = ~pix.data_req & req_dly_q & (state_q != ST_IDLE);
    frame_end_s = line_end_s & (v_disp_q != 11'd0) & (y_cnt_q == (v_disp_q - 11'd1));
    src_eff_s   = start_s ? norm_src(src_sel) : active_src_q;
    h_eff_s     = start_s ? h_disp : h_disp_q;
    fixed_eff_s = start_s ? fixed_color : fixed_q;
    bar_w_s     = (h_eff_s < 11'd8) ? 8'd1 : h_eff_s[10:3];
    serving_s   = pix.data_req & ((state_q != ST_IDLE) | start_s);
    run_like_s  = (state_q == ST_RUN) | start_s;
    rd_en_s     = pix.data_req & run_like_s & (src_eff_s == SRC_FIFO) & ~pix.fifo_empty;
    urun_set_s  = pix.data_req & run_like_s & (src_eff_s == SRC_FIFO) & pix.fifo_empty;
    lost_s      = serving_s & (urun_set_s | (state_q == ST_UNDERRUN));
  end

  lcd_colorbar_gen u_bar (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (serving_s),
    .clr   (line_end_s),
    .x_cnt (x_cnt_q),
    .bar_w (bar_w_s),
    .color (bar_color_s)
  );

  // Next state, counters and pixel selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = start_s ? (urun_set_s ? ST_UNDERRUN : ST_RUN) : ST_IDLE;
      ST_RUN:      state_d = urun_set_s ? ST_UNDERRUN : ST_RUN;
      ST_UNDERRUN: state_d = frame_end_s ? ST_RUN : ST_UNDERRUN;
      default:     state_d = ST_IDLE;
    endcase

    if (line_end_s) begin
      x_cnt_d = 11'd0;
      y_cnt_d = frame_end_s ? 11'd0 : y_cnt_q + 11'd1;
    end else if (serving_s) begin
      x_cnt_d = x_cnt_q + 11'd1;
      y_cnt_d = y_cnt_q;
    end else begin
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
    end

    if (!serving_s) begin
      pixel_d = pixel_q;
    end else if (lost_s) begin
      pixel_d = UNDERRUN_COLOR;
    end else begin
      case (src_eff_s)
        SRC_FIFO: pixel_d = pix.fifo_dout;
        SRC_BAR:  pixel_d = bar_color_s;
        default:  pixel_d = fixed_eff_s;
      endcase
    end

    underrun_d = urun_set_s | (underrun_q & ~err_clr);
  end

  // Scheduler state, configuration snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_dly_q    <= 1'b0;
      x_cnt_q      <= 11'd0;
      y_cnt_q      <= 11'd0;
      h_disp_q     <= 11'd0;
      v_disp_q     <= 11'd0;
      fixed_q      <= 16'h0000;
      active_src_q <= SRC_FIXED;
      pixel_q      <= IDLE_COLOR;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_dly_q    <= pix.data_req;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      pixel_q      <= pixel_d;
      frame_done_q <= frame_end_s;
      underrun_q   <= underrun_d;
      if (start_s | frame_end_s) begin
        h_disp_q     <= h_disp;
        v_disp_q     <= v_disp;
        fixed_q      <= fixed_color;
        active_src_q <= norm_src(src_sel);
      end else begin
        h_disp_q     <= h_disp_q;
        v_disp_q     <= v_disp_q;
        fixed_q      <= fixed_q;
        active_src_q <= active_src_q;
      end
    end
  end

  assign pix.pixel_data = pixel_q;
  assign pix.fifo_rd_en = rd_en_s;
  assign active_src     = active_src_q;
  assign frame_done     = frame_done_q;
  assign underrun       = underrun_q;

`ifdef LCD_SRC_STATS_EN
  logic [15:0] urun_cnt_q, frm_cnt_q;

  // Lost-pixel count saturates; frame count wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      urun_cnt_q <= 16'd0;
      frm_cnt_q  <= 16'd0;
    end else begin
      urun_cnt_q <= (lost_s && (urun_cnt_q != 16'hFFFF)) ? urun_cnt_q + 16'd1 : urun_cnt_q;
      frm_cnt_q  <= frame_end_s ? frm_cnt_q + 16'd1 : frm_cnt_q;
    end
  end

  assign underrun_cnt = urun_cnt_q;
  assign frame_cnt    = frm_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_src_sched.sv
// Directed bench for lcd_src_sched with a small FWFT FIFO model and reduced
// frame sizes; expected pixels are hand-computed per scenario.
module tb_lcd_src_sched;
  import lcd_sched_pkg::*;

  localparam int BLANK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_disp, v_disp;
  logic [1:0]  src_sel;
  logic [15:0] fixed_color;
  logic [1:0]  active_src;
  logic        frame_done, underrun, err_clr;
`ifdef LCD_SRC_STATS_EN
  logic [15:0] underrun_cnt, frame_cnt;
`endif

  lcd_src_sched_if ifc ();

  lcd_src_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix         (ifc),
    .h_disp      (h_disp),
    .v_disp      (v_disp),
    .src_sel     (src_sel),
    .fixed_color (fixed_color),
    .active_src  (active_src),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .err_clr     (err_clr)
`ifdef LCD_SRC_STATS_EN
    ,
    .underrun_cnt(underrun_cnt),
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:1023];
  logic [15:0] got [0:1023];
  int rd_ptr, wr_ptr, pop_cnt, fd_cnt;
  int n_chk, n_pass;
  int fd0, pop0;

  assign ifc.fifo_empty = (rd_ptr == wr_ptr);
  assign ifc.fifo_dout  = mem[rd_ptr];

  // FWFT FIFO pop and frame_done pulse counting.
  always @(posedge clk) begin
    if (ifc.fifo_rd_en) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic push_words(input int n, input logic [15:0] seed);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = seed + 16'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic set_cfg(input logic [10:0] h, input logic [10:0] v, input logic [1:0] s,
                         input logic [15:0] fc);
    h_disp = h; v_disp = v; src_sel = s; fixed_color = fc;
  endtask

  task automatic do_reset();
    ifc.data_req = 1'b0;
    err_clr = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_ptr = rd_ptr;
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; pixel k is visible one clock after its request.
  task automatic drive_line(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      ifc.data_req = 1'b1;
      @(posedge clk); #1;
      got[base + k] = ifc.pixel_data;
    end
    ifc.data_req = 1'b0;
    repeat (BLANK) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int h, input int v);
    for (int y = 0; y < v; y++) drive_line(h, y * h);
  endtask

  initial begin
    rst_n = 1'b1;
    ifc.data_req = 1'b0;
    err_clr = 1'b0;
    set_cfg(11'd0, 11'd0, 2'd0, 16'h0000);
    do_reset();

    check_eq("rst_pixel", ifc.pixel_data, 16'h0000);
    check_eq("rst_rd_en", ifc.fifo_rd_en, 1'b0);
    check_eq("rst_active_src", active_src, 2'd0);
    check_eq("rst_frame_done", frame_done, 1'b0);
    check_eq("rst_underrun", underrun, 1'b0);
`ifdef LCD_SRC_STATS_EN
    check_eq("rst_urun_cnt", underrun_cnt, 16'd0);
    check_eq("rst_frame_cnt", frame_cnt, 16'd0);
`endif

    // Colour bar 480 wide, two lines.
    set_cfg(11'd480, 11'd2, 2'd1, 16'h0000);
    fd0 = fd_cnt;
    drive_line(480, 0);
    check_eq("bar_fd_line0", fd_cnt - fd0, 0);
    drive_line(480, 480);
    check_eq("bar_px0", got[0], 16'hFFFF);
    check_eq("bar_px59", got[59], 16'hFFFF);
    check_eq("bar_px60", got[60], 16'hFFE0);
    check_eq("bar_px120", got[120], 16'h07FF);
    check_eq("bar_px479", got[479], 16'h0000);
    check_eq("bar_l1_px60", got[540], 16'hFFE0);
    check_eq("bar_active", active_src, 2'd1);
    check_eq("bar_fd_frame", fd_cnt - fd0, 1);

    // Narrow bars: bar_w forced to 1, index saturates on black.
    do_reset();
    set_cfg(11'd4, 11'd1, 2'd1, 16'h0000);
    fd0 = fd_cnt;
    drive_line(10, 0);
    check_eq("nb_px1", got[1], 16'hFFE0);
    check_eq("nb_px3", got[3], 16'h07E0);
    check_eq("nb_px6", got[6], 16'h001F);
    check_eq("nb_px9", got[9], 16'h0000);
    check_eq("nb_fd", fd_cnt - fd0, 1);

    // FIFO source, full frame of data.
    do_reset();
    set_cfg(11'd16, 11'd4, 2'd2, 16'h0000);
    push_words(64, 16'hA000);
    pop0 = pop_cnt;
    drive_frame(16, 4);
    for (int k = 0; k < 64; k++) check_eq($sformatf("fifo_px%0d", k), got[k], 16'hA000 + 16'(k));
    check_eq("fifo_pops", pop_cnt - pop0, 64);
    check_eq("fifo_underrun", underrun, 1'b0);
    check_eq("fifo_active", active_src, 2'd2);

    // FIFO runs dry at pixel 20, refilled for the next frame.
    do_reset();
    set_cfg(11'd16, 11'd4, 2'd2, 16'h0000);
    push_words(20, 16'h5000);
    pop0 = pop_cnt;
    drive_frame(16, 4);
    check_eq("ur_px19", got[19], 16'h5013);
    check_eq("ur_px20", got[20], 16'hF800);
    check_eq("ur_px63", got[63], 16'hF800);
    check_eq("ur_flag", underrun, 1'b1);
    check_eq("ur_pops", pop_cnt - pop0, 20);
    push_words(64, 16'h6000);
    drive_frame(16, 4);
    check_eq("ur_f1_px0", got[0], 16'h6000);
    check_eq("ur_f1_px63", got[63], 16'h603F);
    check_eq("ur_sticky", underrun, 1'b1);
`ifdef LCD_SRC_STATS_EN
    check_eq("ur_lost_cnt", underrun_cnt, 16'd44);
    check_eq("ur_frame_cnt", frame_cnt, 16'd2);
`endif

    // Mid-frame src_sel change waits for the frame end.
    do_reset();
    set_cfg(11'd16, 11'd4, 2'd0, 16'h001F);
    pop0 = pop_cnt;
    drive_line(16, 0);
    drive_line(16, 16);
    src_sel = 2'd2;
    push_words(64, 16'hC000);
    drive_line(16, 32);
    check_eq("sw_active_mid", active_src, 2'd0);
    drive_line(16, 48);
    check_eq("sw_px32", got[32], 16'h001F);
    check_eq("sw_px63", got[63], 16'h001F);
    check_eq("sw_active_end", active_src, 2'd2);
    check_eq("sw_no_pops", pop_cnt - pop0, 0);
    drive_frame(16, 4);
    check_eq("sw_f1_px0", got[0], 16'hC000);
    check_eq("sw_f1_pops", pop_cnt - pop0, 64);

    // err_clr coinciding with a new underrun: set wins.
    do_reset();
    set_cfg(11'd16, 11'd2, 2'd2, 16'h0000);
    ifc.data_req = 1'b1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    check_eq("ec_set_wins", underrun, 1'b1);
    check_eq("ec_pixel", ifc.pixel_data, 16'hF800);
    ifc.data_req = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_eq("ec_hold", underrun, 1'b1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check_eq("ec_cleared", underrun, 1'b0);
`ifdef LCD_SRC_STATS_EN
    check_eq("ec_lost_cnt", underrun_cnt, 16'd1);
`endif

    // Asynchronous reset in the middle of line 2, then resync.
    do_reset();
    set_cfg(11'd16, 11'd4, 2'd1, 16'h0000);
    drive_line(16, 0);
    drive_line(16, 16);
    for (int k = 0; k < 5; k++) begin
      ifc.data_req = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("ar_pre_pixel", ifc.pixel_data, 16'h07FF);
    #3 rst_n = 1'b0;
    #1;
    check_eq("ar_pixel", ifc.pixel_data, 16'h0000);
    check_eq("ar_active", active_src, 2'd0);
    check_eq("ar_rd_en", ifc.fifo_rd_en, 1'b0);
    ifc.data_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fd0 = fd_cnt;
    drive_line(16, 0);
    drive_line(16, 16);
    check_eq("ar_px0", got[0], 16'hFFFF);
    check_eq("ar_px2", got[2], 16'hFFE0);
    check_eq("ar_fd_half", fd_cnt - fd0, 0);
    drive_line(16, 32);
    drive_line(16, 48);
    check_eq("ar_fd_frame", fd_cnt - fd0, 1);

    // v_disp==0 never ends a frame; reserved source acts as fixed.
    do_reset();
    set_cfg(11'd8, 11'd0, 2'd3, 16'h1234);
    fd0 = fd_cnt;
    drive_frame(8, 3);
    check_eq("v0_px0", got[0], 16'h1234);
    check_eq("v0_px23", got[23], 16'h1234);
    check_eq("v0_active", active_src, 2'd0);
    check_eq("v0_no_fd", fd_cnt - fd0, 0);
    check_eq("v0_hold", ifc.pixel_data, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
